radix4_issue: RTL
=================

Name: radix4_issue

Overview:
Operand-side front end for the iterative radix-4 multiplier (clk/nd/a/b -> q/valid). It accepts signed operand pairs through a ready/valid stream and buffers them in a small FIFO. It issues one single-cycle nd pulse per pair to the multiplier and never overlaps operations. Each product is captured into a held result register that a downstream consumer drains with a ready/valid handshake.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
DEPTH, 4, operand FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
s_valid  input  1  an operand pair is offered.
s_ready  output  1  FIFO can accept a pair; equals !full, driven from registered state.
s_a  input  WIDTH  signed operand a.
s_b  input  WIDTH  signed operand b.
m_nd  output  1  new-data strobe to the multiplier.
m_a  output  WIDTH  operand a to the multiplier.
m_b  output  WIDTH  operand b to the multiplier.
m_q  input  2*WIDTH  multiplier product.
m_valid  input  1  multiplier result valid; may be a pulse or a level held until the next nd.
r_valid  output  1  result held.
r_ready  input  1  consumer accepts the result.
r_q  output  2*WIDTH  captured product.
level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, level=0, s_ready=1, m_nd=0, m_a=m_b=0, r_valid=0, r_q=0, state=IDLE. Reset in any state aborts the operation in flight. The pending multiplier result is discarded; m_valid is ignored in IDLE.
- Push: when s_valid && s_ready at the edge, write {s_a,s_b} at the write pointer. The pointer wraps modulo DEPTH.
- Pop: occurs on the ISSUE entry edge. A push and a pop in the same cycle leave level unchanged.
- When full, s_ready=0 and the push is refused even if a pop happens in that cycle. s_ready never depends combinationally on state.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, HOLD.
- IDLE: if the FIFO is non-empty and r_valid=0 -> ISSUE. On this edge the head is popped, m_a/m_b are registered from it and m_nd is set to 1.
- ISSUE: lasts exactly one cycle; m_nd=1 only here. Next state is WAIT_LO, m_nd=0. m_a/m_b hold their value until the next issue.
- WAIT_LO: wait for m_valid=0, which covers a stale level valid from the previous result. On m_valid=0 -> WAIT_HI.
- WAIT_HI: on m_valid=1, capture r_q<=m_q, set r_valid=1, go to HOLD.
- HOLD: r_valid and r_q are stable until r_ready=1.
  - On r_valid && r_ready: clear r_valid.
  - If the FIFO is non-empty on that same edge, go directly to ISSUE (pop and set m_nd). This is back-to-back issue with no IDLE cycle.
  - Otherwise go to IDLE.
- Exactly one nd per accepted pair. Results emerge in acceptance order. No pair is lost or duplicated across FIFO wrap-around.
- Arithmetic is performed by the multiplier; this block passes m_q through bit-exact (2*WIDTH, two's complement).
- Minimum latency from push into an empty FIFO with idle state to r_valid = 1 (IDLE->ISSUE) + 1 (ISSUE) + multiplier latency + 1 (capture).

Test Plan:
- Single pair 10,20 after reset -> one m_nd pulse with m_a=10, m_b=20; r_q=200 with r_valid held until r_ready; level returns to 0.
- Three pairs pushed back-to-back: (10,20), (100,200), (-11,-21), with r_ready tied high -> r_q sequence 200, 20000, 231. Exactly three m_nd pulses, non-overlapping, each issued the cycle after the previous result is consumed.
- Push DEPTH+2 pairs with r_ready=0 -> s_ready drops once level=DEPTH (4). Only the first result is held and the remainder stays queued. After releasing r_ready, all accepted products appear in order with correct wrap-around.
- Simultaneous push and pop at level=2 -> level stays 2 and data order is preserved. Push while full -> refused, level stays 4.
- Multiplier model holding m_valid high after the previous result -> no capture until m_valid falls and rises again. The stale q is never presented on r_q.
- reset_n asserted in WAIT_HI with 2 pairs queued -> outputs immediately at reset values. After release, m_valid=1 is ignored, no r_valid appears, and level=0.

Source files
------------

// File: rtl/radix4_issue.sv
// radix4_issue: operand FIFO + issue sequencer for an iterative radix-4 multiplier.
// Ports: s_* operand stream in, m_* multiplier side, r_* held result out, level = FIFO occupancy.
module radix4_issue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_a,
  input  logic [WIDTH-1:0]         s_b,
  output logic                     m_nd,
  output logic [WIDTH-1:0]         m_a,
  output logic [WIDTH-1:0]         m_b,
  input  logic [2*WIDTH-1:0]       m_q,
  input  logic                     m_valid,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [2*WIDTH-1:0]       r_q,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_HOLD
  } state_t;

  state_t r_state;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LW-1:0]      r_level;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_consume;
  logic [2*WIDTH-1:0] w_head;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign s_ready   = !w_full;
  assign level     = r_level;
  assign w_push    = s_valid && !w_full;
  assign w_consume = (r_state == S_HOLD) && r_valid && r_ready;
  // Pop happens only on the edge that enters ISSUE.
  assign w_pop     = !w_empty &&
                     (((r_state == S_IDLE) && !r_valid) || w_consume);
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_a, s_b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      m_nd    <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
    end else begin
      m_nd <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_ISSUE;
            m_nd    <= 1'b1;
            m_a     <= w_head[2*WIDTH-1:WIDTH];
            m_b     <= w_head[WIDTH-1:0];
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_LO;
        end
        // A level-style valid left over from the last result must drop first.
        S_WAIT_LO: begin
          if (!m_valid) begin
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (m_valid) begin
            r_q     <= m_q;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            r_valid <= 1'b0;
            if (w_pop) begin
              r_state <= S_ISSUE;
              m_nd    <= 1'b1;
              m_a     <= w_head[2*WIDTH-1:WIDTH];
              m_b     <= w_head[WIDTH-1:0];
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
